tap_gen2: RTL and testbench
===========================

Name: tap_gen2

Overview:
Parametrised second-generation JTAG TAP controller for the fabric's test/config port. It implements the full 16-state IEEE 1149.1 TAP FSM and a configurable-length instruction register (IR), and drives the fabric's pins through a boundary-scan chain of configurable width. It adds CLAMP and a word-counted streaming PROGRAM path that delivers CFG_WIDTH-bit configuration words to the fabric loader.

Parameters:
IR_LEN, 4, instruction register length in bits (>=3)
PINS_IN_COUNT, 4, number of input boundary cells
PINS_OUT_COUNT, 4, number of output boundary cells
CFG_WIDTH, 32, configuration word width
CNT_W, 16, width of the programmed-word counter
IDCODE_VAL, 32'h1000_0001, IDCODE capture value; bit 0 is always 1

Ports:
tck  in  1  test clock; FSM and registers update on rising edge, tdo on falling edge
trst_n  in  1  synchronous active-low reset, sampled on rising tck
tms  in  1  test mode select
tdi  in  1  test data in
tdo  out  1  test data out
pins_in  in  PINS_IN_COUNT  external pad inputs
pins_out  out  PINS_OUT_COUNT  external pad outputs
logic_pins_in  out  PINS_IN_COUNT  inputs presented to fabric logic
logic_pins_out  in  PINS_OUT_COUNT  outputs from fabric logic
active  out  1  PROGRAM instruction loaded and FSM not in Test-Logic-Reset
config_data  out  CFG_WIDTH  last completed configuration word
config_strobe  out  1  one-tck pulse when config_data is updated
cfg_count  out  CNT_W  words delivered since PROGRAM became active

Behaviour:
- Reset (trst_n=0 at rising tck):
  - FSM enters Test-Logic-Reset (TLR); IR = IDCODE.
  - Boundary shift and update registers, config_data, cfg_count and bypass bit clear to 0; config_strobe=0.
  - The tdo falling-edge register loads 0 while trst_n=0.
- TMS=1 for 5 rising edges from any state also reaches TLR. TLR applies the same IR/update/counter clears as reset, but does not clear config_data.
- FSM: standard 1149.1 transitions on rising tck.
- Instruction encodings (IR_LEN bits, zero-extended; all-ones=BYPASS):
  - EXTEST=0
  - IDCODE=1
  - SAMPLE/PRELOAD=2
  - INTEST=3
  - CLAMP=4
  - PROGRAM=5
  - Any other code acts as BYPASS.
- IR path:
  - Capture-IR loads ...0001 (bits[1:0]=01).
  - Shift-IR: tdi enters the MSB and the LSB goes to tdo, LSB first.
  - Update-IR copies the shift register to IR.
- DR select:
  - IDCODE: 32-bit register; Capture loads IDCODE_VAL.
  - BYPASS/CLAMP: 1-bit register; Capture loads 0.
  - EXTEST/SAMPLE/INTEST: boundary register, length PINS_IN_COUNT+PINS_OUT_COUNT, with input cells in the low bits. Capture loads {logic_pins_out, pins_in}.
  - PROGRAM: CFG_WIDTH shift register.
- All DR shifting is LSB first: tdi enters the MSB, tdo takes bit 0. Update-DR copies the boundary shift register into the boundary update register only for boundary instructions.
- Pin muxing (combinational on IR):
  - pins_out = upd[out] when IR is EXTEST or CLAMP, else logic_pins_out.
  - logic_pins_in = upd[in] when IR is INTEST, else pins_in.
- tdo:
  - Registered on falling tck from the selected register's bit 0.
  - Valid only in Shift-IR/Shift-DR; 0 otherwise. There is no tristate.
- PROGRAM streaming:
  - A bit counter (log2 CFG_WIDTH bits) increments on each rising tck in Shift-DR.
  - When it reaches CFG_WIDTH-1 it wraps to 0. On the following edge, config_data <= the completed word (first-shifted bit = bit 0), config_strobe=1 for exactly one cycle, and cfg_count increments.
  - Words may span Exit1/Pause/Exit2 excursions; the bit counter holds outside Shift-DR.
  - Update-DR discards a partial word and clears the bit counter; it produces no strobe.
  - cfg_count saturates at all-ones and clears on Update-IR loading PROGRAM.
- active=1 iff IR==PROGRAM and state!=TLR; it drops on the rising edge entering TLR.
- Reset mid-word: partial word lost, no strobe, config_data cleared.

Test Plan:
- Reset then Shift-DR 32 bits in TLR→RTI→DR path → tdo sequence equals IDCODE_VAL LSB first; first bit 1.
- Load IR=2 with pins_in=4'b0100, logic_pins_out=4'b0101; shift 8 bits → tdo shows 0,0,1,0,1,0,1,0. After Update-DR of 8'hA5 and IR=0 → pins_out=4'hA.
- IR=3 (INTEST) with update 8'h3C → logic_pins_in=4'hC. IR=4 (CLAMP) → pins_out holds upd, and DR length is 1 (tdi-to-tdo delay of 1 bit).
- IR=5; shift 64 bits encoding words 32'hFFFFFAB1, 32'h0000FAB0 with a Pause-DR after bit 20 → two strobes, config_data=FFFFFAB1 then 0000FAB0, cfg_count=2, active=1.
- IR=5; shift 20 bits then Update-DR → no strobe, config_data unchanged. Then 5×TMS=1 → active=0, IR=IDCODE.
- Assert trst_n=0 mid-word in PROGRAM → next edge: TLR, config_data=0, cfg_count=0, tdo=0, no strobe.

Source files
------------

// File: rtl/tap_gen2.sv
// tap_gen2: IEEE 1149.1 TAP with boundary scan, CLAMP and a word-streaming PROGRAM path.
// Latency: state/registers on rising tck, tdo on falling tck; no backpressure (tck-paced).
module tap_gen2 #(
  parameter int          IR_LEN         = 4,
  parameter int          PINS_IN_COUNT  = 4,
  parameter int          PINS_OUT_COUNT = 4,
  parameter int          CFG_WIDTH      = 32,
  parameter int          CNT_W          = 16,
  parameter logic [31:0] IDCODE_VAL     = 32'h1000_0001
) (
  input  logic                      tck,
  input  logic                      trst_n,
  input  logic                      tms,
  input  logic                      tdi,
  output logic                      tdo,
  input  logic [PINS_IN_COUNT-1:0]  pins_in,
  output logic [PINS_OUT_COUNT-1:0] pins_out,
  output logic [PINS_IN_COUNT-1:0]  logic_pins_in,
  input  logic [PINS_OUT_COUNT-1:0] logic_pins_out,
  output logic                      active,
  output logic [CFG_WIDTH-1:0]      config_data,
  output logic                      config_strobe,
  output logic [CNT_W-1:0]          cfg_count
);

  localparam int BND_LEN = PINS_IN_COUNT + PINS_OUT_COUNT;
  localparam int BC_W    = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CFG_WIDTH - 1);

  localparam logic [IR_LEN-1:0] I_EXTEST  = IR_LEN'(0);
  localparam logic [IR_LEN-1:0] I_IDCODE  = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] I_SAMPLE  = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] I_INTEST  = IR_LEN'(3);
  localparam logic [IR_LEN-1:0] I_CLAMP   = IR_LEN'(4);
  localparam logic [IR_LEN-1:0] I_PROGRAM = IR_LEN'(5);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PA_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PA_IR, S_EX2_IR, S_UPD_IR
  } state_t;

  state_t               state;
  logic [IR_LEN-1:0]    ir;
  logic [IR_LEN-1:0]    ir_sr;
  logic [31:0]          idc_sr;
  logic                 byp;
  logic [BND_LEN-1:0]   bnd_sr;
  logic [BND_LEN-1:0]   bnd_upd;
  logic [CFG_WIDTH-1:0] prog_sr;
  logic [BC_W-1:0]      bit_cnt;
  logic                 word_done;

  logic is_prog, is_idc, is_bnd, going_tlr, dr_bit0;

  assign is_prog = (ir == I_PROGRAM);
  assign is_idc  = (ir == I_IDCODE);
  assign is_bnd  = (ir == I_EXTEST) || (ir == I_SAMPLE) || (ir == I_INTEST);
  // TLR is only entered from Select-IR or by staying in TLR, both with tms high.
  assign going_tlr = tms && ((state == S_TLR) || (state == S_SEL_IR));

  assign dr_bit0 = is_prog ? prog_sr[0] :
                   is_idc  ? idc_sr[0]  :
                   is_bnd  ? bnd_sr[0]  : byp;

  assign pins_out      = ((ir == I_EXTEST) || (ir == I_CLAMP)) ?
                         bnd_upd[BND_LEN-1:PINS_IN_COUNT] : logic_pins_out;
  assign logic_pins_in = (ir == I_INTEST) ? bnd_upd[PINS_IN_COUNT-1:0] : pins_in;
  assign active        = is_prog && (state != S_TLR);

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      state         <= S_TLR;
      ir            <= I_IDCODE;
      ir_sr         <= '0;
      idc_sr        <= '0;
      byp           <= 1'b0;
      bnd_sr        <= '0;
      bnd_upd       <= '0;
      prog_sr       <= '0;
      bit_cnt       <= '0;
      word_done     <= 1'b0;
      config_data   <= '0;
      config_strobe <= 1'b0;
      cfg_count     <= '0;
    end else begin
      config_strobe <= 1'b0;
      word_done     <= 1'b0;

      case (state)
        S_TLR:    state <= tms ? S_TLR    : S_RTI;
        S_RTI:    state <= tms ? S_SEL_DR : S_RTI;
        S_SEL_DR: state <= tms ? S_SEL_IR : S_CAP_DR;
        S_CAP_DR: state <= tms ? S_EX1_DR : S_SH_DR;
        S_SH_DR:  state <= tms ? S_EX1_DR : S_SH_DR;
        S_EX1_DR: state <= tms ? S_UPD_DR : S_PA_DR;
        S_PA_DR:  state <= tms ? S_EX2_DR : S_PA_DR;
        S_EX2_DR: state <= tms ? S_UPD_DR : S_SH_DR;
        S_UPD_DR: state <= tms ? S_SEL_DR : S_RTI;
        S_SEL_IR: state <= tms ? S_TLR    : S_CAP_IR;
        S_CAP_IR: state <= tms ? S_EX1_IR : S_SH_IR;
        S_SH_IR:  state <= tms ? S_EX1_IR : S_SH_IR;
        S_EX1_IR: state <= tms ? S_UPD_IR : S_PA_IR;
        S_PA_IR:  state <= tms ? S_EX2_IR : S_PA_IR;
        S_EX2_IR: state <= tms ? S_UPD_IR : S_SH_IR;
        S_UPD_IR: state <= tms ? S_SEL_DR : S_RTI;
        default:  state <= S_TLR;
      endcase

      // The word completed on the previous edge is still intact in prog_sr here.
      if (word_done) begin
        config_data   <= prog_sr;
        config_strobe <= 1'b1;
        if (cfg_count != '1) cfg_count <= cfg_count + 1'b1;
      end

      case (state)
        S_CAP_IR: ir_sr <= IR_LEN'(1);
        S_SH_IR:  ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
        S_UPD_IR: begin
          ir <= ir_sr;
          if (ir_sr == I_PROGRAM) begin
            cfg_count <= '0;
            bit_cnt   <= '0;
          end
        end
        S_CAP_DR: begin
          idc_sr <= IDCODE_VAL | 32'd1;
          byp    <= 1'b0;
          bnd_sr <= {logic_pins_out, pins_in};
        end
        S_SH_DR: begin
          if (is_idc) idc_sr <= {tdi, idc_sr[31:1]};
          if (is_bnd) bnd_sr <= {tdi, bnd_sr[BND_LEN-1:1]};
          byp <= tdi;
          if (is_prog) begin
            prog_sr <= {tdi, prog_sr[CFG_WIDTH-1:1]};
            if (bit_cnt == BC_LAST) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_UPD_DR: begin
          if (is_bnd)  bnd_upd <= bnd_sr;
          if (is_prog) bit_cnt <= '0;
        end
        default: ;
      endcase

      if (going_tlr) begin
        ir        <= I_IDCODE;
        bnd_sr    <= '0;
        bnd_upd   <= '0;
        byp       <= 1'b0;
        bit_cnt   <= '0;
        cfg_count <= '0;
      end
    end
  end

  always_ff @(negedge tck) begin
    if (!trst_n)                tdo <= 1'b0;
    else if (state == S_SH_IR)  tdo <= ir_sr[0];
    else if (state == S_SH_DR)  tdo <= dr_bit0;
    else                        tdo <= 1'b0;
  end

endmodule

// File: tb/tb_tap_gen2.sv
// Directed bench for tap_gen2: pin-mux vector table plus hand-written IDCODE, CLAMP/BYPASS and PROGRAM sequences.
module tb_tap_gen2;

  logic        tck = 1'b0;
  logic        trst_n, tms, tdi;
  logic        tdo;
  logic [3:0]  pins_in, pins_out, logic_pins_in, logic_pins_out;
  logic        active, config_strobe;
  logic [31:0] config_data;
  logic [15:0] cfg_count;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic [31:0] sw[$];

  tap_gen2 dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo),
    .pins_in(pins_in), .pins_out(pins_out),
    .logic_pins_in(logic_pins_in), .logic_pins_out(logic_pins_out),
    .active(active), .config_data(config_data),
    .config_strobe(config_strobe), .cfg_count(cfg_count)
  );

  always #5 tck = ~tck;

  always @(negedge tck) begin
    if (config_strobe === 1'b1) begin
      strobe_cnt++;
      sw.push_back(config_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One tck cycle: sample tdo for the current state, drive tms/tdi, then pass the rising edge.
  task automatic step(input logic t, input logic d, output logic o);
    @(negedge tck);
    #1;
    o   = tdo;
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic step_n(input logic t);
    logic o;
    step(t, 1'b0, o);
  endtask

  task automatic shift_bits(input logic [63:0] data, input int n, input bit do_exit,
                            output logic [63:0] got);
    logic o;
    got = '0;
    for (int i = 0; i < n; i++) begin
      step(do_exit && (i == n - 1), data[i], o);
      got[i] = o;
    end
  endtask

  task automatic enter_shdr();
    step_n(1'b1);
    step_n(1'b0);
    step_n(1'b0);
  endtask

  task automatic exit_update();
    step_n(1'b1);
    step_n(1'b0);
  endtask

  task automatic load_ir(input logic [3:0] code);
    logic [63:0] got;
    step_n(1'b1);
    step_n(1'b1);
    step_n(1'b0);
    step_n(1'b0);
    shift_bits({60'd0, code}, 4, 1'b1, got);
    chk("ir_capture", got, 64'h1);
    exit_update();
  endtask

  typedef struct {
    logic [3:0] ir;
    logic [7:0] upd;
    logic [3:0] pin;
    logic [3:0] lpo;
    logic [7:0] exp_cap;
    logic [3:0] exp_po;
    logic [3:0] exp_lpi;
  } vec_t;

  vec_t vt[7];
  localparam logic [31:0] W0 = 32'hFFFF_FAB1;
  localparam logic [31:0] W1 = 32'h0000_FAB0;
  localparam logic [31:0] W2 = 32'h1234_5678;
  localparam logic [31:0] W3 = 32'hCAFE_F40D;

  initial begin
    logic [63:0] got;
    logic [63:0] stream;

    vt[0] = '{4'd0,  8'hA5, 4'h4, 4'h5, 8'h54, 4'hA, 4'h4};
    vt[1] = '{4'd3,  8'h3C, 4'h9, 4'h6, 8'h69, 4'h6, 4'hC};
    vt[2] = '{4'd4,  8'h5E, 4'h1, 4'h2, 8'h21, 4'h5, 4'h1};
    vt[3] = '{4'd1,  8'hF0, 4'hE, 4'h7, 8'h7E, 4'h7, 4'hE};
    vt[4] = '{4'hF,  8'h0F, 4'h3, 4'h8, 8'h83, 4'h8, 4'h3};
    vt[5] = '{4'd2,  8'hC3, 4'hA, 4'h5, 8'h5A, 4'h5, 4'hA};
    vt[6] = '{4'h9,  8'h77, 4'h6, 4'hB, 8'hB6, 4'hB, 4'h6};

    trst_n = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    pins_in = 4'h3;
    logic_pins_out = 4'h9;
    step_n(1'b1);
    step_n(1'b1);
    chk("rst_tdo", tdo, 0);
    chk("rst_active", active, 0);
    chk("rst_cfg_data", config_data, 0);
    chk("rst_cfg_count", cfg_count, 0);
    chk("rst_strobe", config_strobe, 0);
    chk("rst_pins_out", pins_out, 4'h9);
    chk("rst_logic_pins_in", logic_pins_in, 4'h3);
    trst_n = 1'b1;

    step_n(1'b0);
    enter_shdr();
    shift_bits(64'd0, 32, 1'b1, got);
    chk("idcode_shift", got, 64'h1000_0001);
    exit_update();

    for (int v = 0; v < 7; v++) begin
      pins_in = vt[v].pin;
      logic_pins_out = vt[v].lpo;
      load_ir(4'd2);
      enter_shdr();
      shift_bits({56'd0, vt[v].upd}, 8, 1'b1, got);
      chk("bnd_capture", got, {56'd0, vt[v].exp_cap});
      exit_update();
      load_ir(vt[v].ir);
      chk("mux_pins_out", pins_out, vt[v].exp_po);
      chk("mux_logic_pins_in", logic_pins_in, vt[v].exp_lpi);
    end

    load_ir(4'd4);
    chk("clamp_pins_out", pins_out, 4'h7);
    enter_shdr();
    shift_bits(64'hB2, 8, 1'b1, got);
    chk("clamp_dr_len1", got, 64'h64);
    exit_update();
    chk("clamp_pins_after_upd", pins_out, 4'h7);

    load_ir(4'hF);
    enter_shdr();
    shift_bits(64'h5B, 8, 1'b1, got);
    chk("bypass_dr_len1", got, 64'hB6);
    exit_update();

    load_ir(4'd5);
    chk("prog_active", active, 1);
    chk("prog_count0", cfg_count, 0);
    stream = {W1, W0};
    enter_shdr();
    shift_bits(stream, 20, 1'b1, got);
    step_n(1'b0);
    step_n(1'b0);
    step_n(1'b1);
    step_n(1'b0);
    shift_bits(stream >> 20, 44, 1'b1, got);
    exit_update();
    chk("prog_strobes", strobe_cnt, 2);
    chk("prog_word0", (sw.size() > 0) ? sw[0] : 32'hxxxx_xxxx, W0);
    chk("prog_word1", (sw.size() > 1) ? sw[1] : 32'hxxxx_xxxx, W1);
    chk("prog_count2", cfg_count, 2);
    chk("prog_data", config_data, W1);
    chk("prog_active_after", active, 1);

    enter_shdr();
    shift_bits(64'hF_FFFF, 20, 1'b1, got);
    exit_update();
    chk("partial_no_strobe", strobe_cnt, 2);
    chk("partial_data_kept", config_data, W1);
    chk("partial_count", cfg_count, 2);

    enter_shdr();
    shift_bits({32'd0, W2}, 32, 1'b1, got);
    exit_update();
    chk("fresh_strobe", strobe_cnt, 3);
    chk("fresh_data", config_data, W2);
    chk("fresh_count", cfg_count, 3);

    for (int i = 0; i < 5; i++) step_n(1'b1);
    chk("tlr_active", active, 0);
    chk("tlr_count", cfg_count, 0);
    chk("tlr_data_kept", config_data, W2);
    step_n(1'b0);
    enter_shdr();
    shift_bits(64'd0, 32, 1'b1, got);
    chk("tlr_ir_idcode", got, 64'h1000_0001);
    exit_update();

    load_ir(4'd5);
    enter_shdr();
    shift_bits({22'd0, 10'h3FF, W3}, 42, 1'b0, got);
    chk("pre_rst_strobe", strobe_cnt, 4);
    chk("pre_rst_count", cfg_count, 1);
    chk("pre_rst_data", config_data, W3);
    trst_n = 1'b0;
    step_n(1'b0);
    chk("midrst_active", active, 0);
    chk("midrst_data", config_data, 0);
    chk("midrst_count", cfg_count, 0);
    chk("midrst_strobe", config_strobe, 0);
    @(negedge tck);
    #1;
    chk("midrst_tdo", tdo, 0);
    chk("midrst_no_strobe", strobe_cnt, 4);
    trst_n = 1'b1;
    step_n(1'b0);
    enter_shdr();
    shift_bits(64'd0, 32, 1'b1, got);
    chk("post_rst_idcode", got, 64'h1000_0001);
    exit_update();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
